quad_pixel_packer: RTL and testbench

Upstream feeder for the watermarking core. Accepts a byte-serial pixel stream with valid/ready handshake and assembles groups of four consecutive bytes into the parallel `Data1`..`Data4` words that the `main` embedding stage consumes. A fill register and an output register decouple the two sides, so the core always sees four stable bytes for as long as a quad is presented. Short final groups at end of frame are padded, and the block tracks quad position within the frame.

---
 rtl/quad_pixel_packer.sv | 105 ++++++++++
 tb/tb_quad_pixel_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_pixel_packer.sv
// Byte-serial to four-lane pixel packer feeding the watermark embedding stage.
// A fill register assembles bytes; an output register holds each quad stable until it is taken.
module quad_pixel_packer #(
    parameter logic [7:0] PAD_VALUE = 8'h00,
    parameter int         QIDX_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [7:0]        Data1,
    output logic [7:0]        Data2,
    output logic [7:0]        Data3,
    output logic [7:0]        Data4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [2:0]        out_count,
    output logic [QIDX_W-1:0] quad_index
);

    // Handshakes: a byte moves when in_valid && in_ready; a quad moves when
    // out_valid && out_ready. in_ready never depends on out_ready.

    localparam logic [QIDX_W-1:0] QIDX_ONE = 1;

    logic [7:0] lane [4];
    logic [1:0] wr_idx;
    logic       fill_full;
    logic [2:0] fill_cnt;
    logic       fill_last;

    logic accept;
    logic transfer;
    logic pop;
    logic fill_done;

    always_comb begin
        in_ready  = !fill_full && !rst;
        accept    = in_valid && in_ready;
        transfer  = fill_full && (!out_valid || out_ready);
        pop       = out_valid && out_ready;
        fill_done = accept && ((wr_idx == 2'd3) || in_last);
    end

    // Fill side: accept and transfer are mutually exclusive because accept needs !fill_full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= 2'd0;
            fill_full <= 1'b0;
            fill_cnt  <= 3'd0;
            fill_last <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane[i] <= 8'h00;
            end
        end else begin
            if (accept) begin
                lane[wr_idx] <= in_data;
                if (fill_done) begin
                    wr_idx    <= 2'd0;
                    fill_full <= 1'b1;
                    fill_cnt  <= {1'b0, wr_idx} + 3'd1;
                    fill_last <= in_last;
                end else begin
                    wr_idx <= wr_idx + 2'd1;
                end
            end
            if (transfer) begin
                fill_full <= 1'b0;
            end
        end
    end

    // Output side: lanes beyond the fill count carry stale bytes, so they are padded here.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_count  <= 3'd0;
            Data1      <= 8'h00;
            Data2      <= 8'h00;
            Data3      <= 8'h00;
            Data4      <= 8'h00;
            quad_index <= '0;
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_last  <= fill_last;
                out_count <= fill_cnt;
                Data1     <= lane[0];
                Data2     <= (fill_cnt > 3'd1) ? lane[1] : PAD_VALUE;
                Data3     <= (fill_cnt > 3'd2) ? lane[2] : PAD_VALUE;
                Data4     <= (fill_cnt > 3'd3) ? lane[3] : PAD_VALUE;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (pop) begin
                quad_index <= out_last ? '0 : quad_index + QIDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_quad_pixel_packer.sv
// Directed bench for quad_pixel_packer: reset, basic quad, streaming, short frame,
// backpressure with simultaneous pop/transfer, and reset mid-operation.
module tb_quad_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  Data1, Data2, Data3, Data4;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  out_count;
    logic [15:0] quad_index;

    int checks   = 0;
    int failures = 0;

    quad_pixel_packer #(.PAD_VALUE(8'hFF), .QIDX_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_count(out_count), .quad_index(quad_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quad(input string tag, input logic [31:0] exp_data,
                            input logic [2:0] exp_cnt, input logic exp_last,
                            input logic [15:0] exp_idx);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {Data1, Data2, Data3, Data4}, exp_data);
        chk({tag, "_count"}, {29'd0, out_count}, {29'd0, exp_cnt});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, exp_last});
        chk({tag, "_qidx"}, {16'd0, quad_index}, {16'd0, exp_idx});
    endtask

    // Offers one byte, waits (bounded) for acceptance, then drops in_valid.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wait_out", {31'd0, out_valid}, 32'd1);
    endtask

    logic [7:0] stream [12];
    logic [7:0] bp     [8];

    initial begin
        int i;
        int k;
        int low_cnt;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        stream = '{8'hC0, 8'h0C, 8'h30, 8'h03, 8'h6A, 8'h72, 8'h6B, 8'hAA,
                   8'h11, 8'h22, 8'h33, 8'h44};
        bp     = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {Data1, Data2, Data3, Data4}, 32'd0);
        chk("rst_qidx", {16'd0, quad_index}, 32'd0);
        chk("rst_count_last", {28'd0, out_count, out_last}, 32'd0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic quad with latency check
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h80; tick();
        in_data = 8'h08; tick();
        in_data = 8'h20; tick();
        in_data = 8'h02; in_last = 1'b1; tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_fill_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk_quad("basic", 32'h80082002, 3'd4, 1'b1, 16'd0);
        tick();
        chk("basic_popped", {31'd0, out_valid}, 32'd0);
        chk("basic_qidx_after_last", {16'd0, quad_index}, 32'd0);

        // Streaming 12 bytes with in_valid held high
        i = 0;
        k = 0;
        low_cnt = 0;
        for (int c = 0; c < 40 && (i < 12 || k < 3); c++) begin
            if (out_valid) begin
                chk("stream_data", {Data1, Data2, Data3, Data4},
                    {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]});
                chk("stream_qidx", {16'd0, quad_index}, k);
                chk("stream_last", {31'd0, out_last}, (k == 2) ? 32'd1 : 32'd0);
                k++;
            end
            if (i < 12) begin
                in_valid = 1'b1;
                in_data  = stream[i];
                in_last  = (i == 11);
                if (!in_ready) low_cnt++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (in_valid && in_ready) begin
                tick();
                i++;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("stream_bytes_sent", i, 32'd12);
        chk("stream_quads_seen", k, 32'd3);
        chk("stream_bubbles", low_cnt, 32'd2);

        // Short frame padded with 0xFF
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        wait_out();
        chk_quad("short", 32'h1122FFFF, 3'd2, 1'b1, 16'd0);
        out_ready = 1'b1;
        tick();
        chk("short_popped", {31'd0, out_valid}, 32'd0);
        chk("short_next_qidx", {16'd0, quad_index}, 32'd0);

        // Backpressure: 8 bytes offered with out_ready low
        out_ready = 1'b0;
        i = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (i < 8);
            in_data  = (i < 8) ? bp[i] : 8'h00;
            in_last  = (i == 7);
            if (in_valid && in_ready) begin
                tick();
                i++;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_bytes_taken", i, 32'd8);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk_quad("bp_first", 32'hA1A2A3A4, 3'd4, 1'b0, 16'd0);
        tick();
        tick();
        tick();
        chk("bp_hold_data", {Data1, Data2, Data3, Data4}, 32'hA1A2A3A4);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        // One-cycle out_ready: pop and transfer on the same edge
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_quad("bp_second", 32'hA5A6A7A8, 3'd4, 1'b1, 16'd1);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_qidx_reset", {16'd0, quad_index}, 32'd0);

        // Reset mid-operation: quad presented plus partial fill
        out_ready = 1'b0;
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        chk("mid_presenting", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {Data1, Data2, Data3, Data4}, 32'd0);
        chk("mid_rst_count_last", {28'd0, out_count, out_last}, 32'd0);
        chk("mid_rst_qidx", {16'd0, quad_index}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_release_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        wait_out();
        chk_quad("after_rst", 32'hD1D2D3D4, 3'd4, 1'b0, 16'd0);
        out_ready = 1'b1;
        tick();
        chk("after_rst_qidx_inc", {16'd0, quad_index}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
